// File: rtl/sdm_decimator.sv
// sdm_decimator
//   Receive side of a first-order sigma-delta bitstream. It recovers WIDTH-bit
//   samples with a sinc2 (two-stage CIC) decimator. The decimation ratio is
//   R = 2^WIDTH, and the internal CIC width is 2*WIDTH+1. Decoded samples are
//   offered on a valid/ready port, with sticky overrun detection.
//
//   Optional feature: define SDM_DEC_SYNC_EN to pass din through a 2-flop
//   synchroniser before sampling. This adds 2 clk from the pin to sampling.
//   The synchroniser flops reset to 1, so the counted quantum x is 0.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   synchronous reset, active-high
//   ena         in   sample strobe: din accepted on edges where ena=1
//   din         in   sigma-delta bitstream (x = ~din is the counted quantum)
//   dout        out  decoded sample (WIDTH bits)
//   dout_valid  out  dout holds an unconsumed sample
//   dout_ready  in   consumer accepts dout when dout_valid & dout_ready
//   overrun     out  sticky: a sample was overwritten before acceptance
//   ovr_clr     in   clears overrun (single-cycle pulse)
module sdm_decimator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int CW = 2 * WIDTH + 1;

  logic [CW-1:0]    i1_q, i1_d;
  logic [CW-1:0]    i2_q, i2_d;
  logic [CW-1:0]    i2_prev_q, i2_prev_d;
  logic [CW-1:0]    c1_prev_q, c1_prev_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             din_s;
  logic [CW-1:0]    x;
  logic [CW-1:0]    c1, c2;
  logic [WIDTH-1:0] q;
  logic             ovr_set;

`ifdef SDM_DEC_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], din};
  end

  // Synchroniser runs every clk, independent of ena; reset to 1 so x=0.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  assign din_s = sync_q[1];
`else
  assign din_s = din;
`endif

  always_comb begin
    x         = {{(CW-1){1'b0}}, ~din_s};
    i1_d      = i1_q;
    i2_d      = i2_q;
    cnt_d     = cnt_q;
    i2_prev_d = i2_prev_q;
    c1_prev_d = c1_prev_q;
    primed_d  = primed_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovr_set   = 1'b0;

    // Integrators; i2 accumulates the already-updated i1.
    if (ena) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_q + x;
      cnt_d = cnt_q + 1'b1;
    end
    tick_d = ena && (cnt_q == '1);

    // The comb stage runs one edge after the frame's last bit.
    // At that point, i2_q already contains that bit.
    c1 = i2_q - i2_prev_q;
    c2 = c1 - c1_prev_q;
    // c2 >> WIDTH spans WIDTH+1 bits. Its top bit is set only when the input
    // is all ones (c2 = R^2), so in that case clamp to full scale.
    q  = c2[CW-1] ? {WIDTH{1'b1}} : c2[CW-2:WIDTH];

    if (tick_q) begin
      i2_prev_d = i2_q;
      c1_prev_d = c1;
      primed_d  = 1'b1;
    end

    // The first tick after reset only fills the comb history.
    if (tick_q && primed_q) begin
      dout_d  = q;
      valid_d = 1'b1;
      ovr_set = valid_q && !dout_ready;
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end

    // A new overrun wins over a coincident clear.
    if (ovr_set)      ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q      <= '0;
      i2_q      <= '0;
      i2_prev_q <= '0;
      c1_prev_q <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      primed_q  <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i2_prev_q <= i2_prev_d;
      c1_prev_q <= c1_prev_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      primed_q  <= primed_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sdm_decimator.sv
// tb_sdm_decimator
//   Scoreboard bench for sdm_decimator (WIDTH=4, R=16). The stimulus pushes
//   the hand-known sample value, together with the edge on which it must
//   appear. A negedge monitor pops an entry on every accepted sample.
module tb_sdm_decimator;

  localparam int W = 4;
  localparam int R = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         din;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         overrun;
  logic         ovr_clr;

  always #5 clk = ~clk;

  sdm_decimator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  typedef struct {
    int val;
    int edge_no;
    bit timed;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;

  // Expected handshake state, advanced once per clock edge.
  bit m_valid, m_ovr, m_primed, m_pend;
  int m_dout, m_pend_val, m_nacc;
  int cur_exp;
  bit timed_mode;

  // Stream source: a constant level, or a first-order sigma-delta DAC.
  bit           use_dac;
  logic         const_din;
  int           dac_data;
  logic [W-1:0] dac_acc;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, expv, edge_cnt);
    end
  endtask

  task automatic model_edge(input logic e);
    bit set_ovr;
    set_ovr = 1'b0;
    if (rst) begin
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_primed = 1'b0;
      m_pend   = 1'b0;
      m_dout   = 0;
      m_nacc   = 0;
      sb.delete();
    end else begin
      if (m_pend) begin
        if (m_primed) begin
          if (m_valid && !dout_ready) begin
            set_ovr = 1'b1;
            sb.delete(sb.size() - 1);
          end
          sb.push_back('{m_pend_val, edge_cnt + 1, timed_mode});
          m_valid = 1'b1;
          m_dout  = m_pend_val;
        end else begin
          m_primed = 1'b1;
        end
      end else if (m_valid && dout_ready) begin
        m_valid = 1'b0;
      end
      if (set_ovr)      m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      m_pend = 1'b0;
      if (e) begin
        m_nacc++;
        if (m_nacc % R == 0) begin
          m_pend     = 1'b1;
          m_pend_val = cur_exp;
        end
      end
    end
  endtask

  task automatic step(input logic e);
    logic [W:0] sum;
    sum = {1'b0, dac_acc} + (W+1)'(dac_data);
    ena = e;
    din = use_dac ? ~sum[W] : const_din;
    model_edge(e);
    @(posedge clk);
    edge_cnt++;
    if (use_dac && e) dac_acc = sum[W-1:0];
    #1;
    chk("dout_valid", dout_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("dout", dout, m_dout);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    dac_acc = '0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t ent;
    if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got dout=%0d at edge %0d, none required", dout, edge_cnt);
      end else begin
        ent = sb.pop_front();
        $display("sample edge %0d dout=%0d expected=%0d", edge_cnt, dout, ent.val);
        chk("sample_value", int'(dout), ent.val);
        if (ent.timed) chk("sample_edge", edge_cnt, ent.edge_no);
      end
    end
  end

  int dac_vals[4] = '{5, 0, 15, 9};

  initial begin
    rst        = 1'b1;
    ena        = 1'b0;
    din        = 1'b1;
    dout_ready = 1'b1;
    ovr_clr    = 1'b0;
    use_dac    = 1'b0;
    const_din  = 1'b1;
    dac_data   = 0;
    dac_acc    = '0;
    timed_mode = 1'b1;
    cur_exp    = 0;

    // Test 1: din=1 constant -> zeros, first sample after 32 bits.
    do_reset();
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_overrun", overrun, 0);
    use_dac = 1'b0; const_din = 1'b1; cur_exp = 0;
    repeat (4 * R + 2) step(1'b1);

    // Test 2: din=0 constant -> saturates to 15.
    do_reset();
    const_din = 1'b0; cur_exp = 15;
    repeat (4 * R + 2) step(1'b1);

    // Test 3: DAC round trip for several codes.
    foreach (dac_vals[k]) begin
      do_reset();
      use_dac = 1'b1; dac_data = dac_vals[k]; cur_exp = dac_vals[k];
      repeat (4 * R + 2) step(1'b1);
    end

    // Test 4: overrun with dout_ready held low over two loads.
    do_reset();
    use_dac = 1'b1; dac_data = 5; cur_exp = 5;
    dout_ready = 1'b0; timed_mode = 1'b0;
    repeat (3 * R) step(1'b1);
    step(1'b0);
    chk("ovr_set", overrun, 1);
    chk("ovr_valid", dout_valid, 1);
    chk("ovr_dout", dout, 5);
    dout_ready = 1'b1;
    step(1'b0);
    chk("ovr_accept_valid", dout_valid, 0);
    ovr_clr = 1'b1;
    step(1'b0);
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    timed_mode = 1'b1;

    // Test 5: ena every other clk, data=9.
    do_reset();
    use_dac = 1'b1; dac_data = 9; cur_exp = 9;
    for (int i = 0; i < 3 * R + 1; i++) begin
      step(1'b1);
      step(1'b0);
    end

    // Test 6: reset after 10 bits of frame 3, then a fresh 32-bit prime.
    do_reset();
    use_dac = 1'b1; dac_data = 5; cur_exp = 5;
    repeat (2 * R + 10) step(1'b1);
    do_reset();
    chk("midreset_dout", dout, 0);
    chk("midreset_valid", dout_valid, 0);
    chk("midreset_overrun", overrun, 0);
    repeat (2 * R) step(1'b1);
    chk("midreset_no_early", dout_valid, 0);
    repeat (R + 2) step(1'b1);

    repeat (4) step(1'b0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
